scs8hd_ha_pipe: RTL and testbench



---
 rtl/scs8hd_ha_pipe.sv | 123 ++++++++++++
 tb/tb_scs8hd_ha_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_ha_pipe.sv
// Pipelined WIDTH-bit adder: {COUT, SUM} = A + B + CIN, carried through STAGES register slices
// with a valid/ready handshake and full backpressure.
module scs8hd_ha_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
`ifdef SC_USE_PG_PIN
  input  logic             vpwr,
  input  logic             vgnd,
  input  logic             vpb,
  input  logic             vnb,
`endif
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int SLICE = (STAGES > 0) ? (WIDTH + STAGES - 1) / STAGES : 1;
  localparam int WP1   = WIDTH + 1;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_params
    $error("scs8hd_ha_pipe: STAGES must lie in 1..WIDTH and WIDTH must be >= 1");
  end

  // Inter-stage chains: index k is what stage k receives.
  logic [STAGES:0]                 rdy_c;
  logic [STAGES-1:0]               vld_c;
  logic [STAGES-1:0]               cry_c;
  logic [STAGES-1:0][WIDTH-1:0]    a_c;
  logic [STAGES-1:0][WIDTH-1:0]    b_c;
  logic [STAGES-1:0][WIDTH-1:0]    sum_c;

  assign rdy_c[STAGES] = OUT_READY;
  assign IN_READY      = rdy_c[0];
  assign vld_c[0]      = IN_VALID;
  assign cry_c[0]      = CIN;
  assign a_c[0]        = A;
  assign b_c[0]        = B;
  assign sum_c[0]      = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Bit range [LO, HI) owned by this stage; an empty stage has LO == HI == WIDTH,
    // which makes the adder below pass the incoming carry straight through.
    localparam int LO = (k * SLICE < WIDTH) ? k * SLICE : WIDTH;
    localparam int HI = ((k + 1) * SLICE < WIDTH) ? (k + 1) * SLICE : WIDTH;

    logic             valid_q;
    logic             carry_q;
    logic             carry_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] slice_m;
    logic [WP1-1:0]   add_w;

    always_comb begin
      slice_m = '0;
      for (int i = 0; i < WIDTH; i++) slice_m[i] = (i >= LO) && (i < HI);
    end

    always_comb begin
      add_w   = {1'b0, a_c[k] & slice_m} + {1'b0, b_c[k] & slice_m} + (WP1'(cry_c[k]) << LO);
      sum_d   = sum_c[k] | (add_w[WIDTH-1:0] & slice_m);
      carry_d = |(add_w >> HI);
    end

    assign rdy_c[k] = !valid_q || rdy_c[k+1];

    // Data only moves with a valid token, so bubbles never disturb held results.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (rdy_c[k]) begin
        valid_q <= vld_c[k];
        if (vld_c[k]) begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] upper_m;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_comb begin
        upper_m = '0;
        for (int i = 0; i < WIDTH; i++) upper_m[i] = (i >= HI);
      end

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy_c[k] && vld_c[k]) begin
          a_q <= a_c[k] & upper_m;
          b_q <= b_c[k] & upper_m;
        end
      end

      assign a_c[k+1]   = a_q;
      assign b_c[k+1]   = b_q;
      assign sum_c[k+1] = sum_q;
      assign cry_c[k+1] = carry_q;
      assign vld_c[k+1] = valid_q;
    end else begin : g_out
      assign SUM       = sum_q;
      assign COUT      = carry_q;
      assign OUT_VALID = valid_q;
    end
  end

endmodule

// File: tb/tb_scs8hd_ha_pipe.sv
// Bench for scs8hd_ha_pipe: four configurations share one stimulus stream and are
// checked against an arithmetic reference with per-DUT result queues.
module tb_scs8hd_ha_pipe;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       CIN = 1'b0;
  logic       OUT_READY = 1'b1;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;

  always #5 CLK = ~CLK;

  logic [3:0] in_rdy, out_vld, cout_v;
  logic [7:0] sum0, sum1, sum2;
  logic [4:0] sum5;

  scs8hd_ha_pipe #(.WIDTH(8), .STAGES(2)) u_d0 (
`ifdef SC_USE_PG_PIN
    .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0),
`endif
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(in_rdy[0]), .A(A), .B(B), .CIN(CIN),
    .OUT_VALID(out_vld[0]), .OUT_READY(OUT_READY), .SUM(sum0), .COUT(cout_v[0]));

  scs8hd_ha_pipe #(.WIDTH(8), .STAGES(8)) u_d1 (
`ifdef SC_USE_PG_PIN
    .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0),
`endif
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(in_rdy[1]), .A(A), .B(B), .CIN(CIN),
    .OUT_VALID(out_vld[1]), .OUT_READY(OUT_READY), .SUM(sum1), .COUT(cout_v[1]));

  scs8hd_ha_pipe #(.WIDTH(8), .STAGES(1)) u_d2 (
`ifdef SC_USE_PG_PIN
    .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0),
`endif
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(in_rdy[2]), .A(A), .B(B), .CIN(CIN),
    .OUT_VALID(out_vld[2]), .OUT_READY(OUT_READY), .SUM(sum2), .COUT(cout_v[2]));

  scs8hd_ha_pipe #(.WIDTH(5), .STAGES(2)) u_d3 (
`ifdef SC_USE_PG_PIN
    .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0),
`endif
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(in_rdy[3]), .A(A[4:0]), .B(B[4:0]),
    .CIN(CIN), .OUT_VALID(out_vld[3]), .OUT_READY(OUT_READY), .SUM(sum5), .COUT(cout_v[3]));

  typedef struct packed {
    logic [7:0]  s;
    logic        c;
    logic [31:0] acc;
  } item_t;

  item_t      expq [4][$];
  int         st [4] = '{2, 8, 1, 2};
  int         wd [4] = '{8, 8, 8, 5};
  int         acc_cnt [4] = '{0, 0, 0, 0};
  logic       hold [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] hs [4];
  logic       hc [4];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_stall = -1;

  function automatic logic [7:0] get_sum(input int d);
    case (d)
      0:       return sum0;
      1:       return sum1;
      2:       return sum2;
      default: return {3'b000, sum5};
    endcase
  endfunction

  // Reference: plain modular arithmetic on the configured width.
  function automatic item_t ref_add(input int d);
    item_t it;
    int m = (1 << wd[d]) - 1;
    int r = (int'(A) & m) + (int'(B) & m) + int'(CIN);
    it.s   = 8'(r & m);
    it.c   = 1'((r >> wd[d]) & 1);
    it.acc = 32'(cyc);
    return it;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d cycle %0d: observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int d, input logic v, input logic [7:0] s, input logic c);
    chk({tag, "_valid"}, d, 32'(out_vld[d]), 32'(v));
    chk({tag, "_sum"},   d, 32'(get_sum(d)), 32'(s));
    chk({tag, "_cout"},  d, 32'(cout_v[d]),  32'(c));
  endtask

  // One clock cycle: entered at a falling edge with inputs already driven.
  task automatic cycle();
    item_t e;
    #1;
    if (!OUT_READY) last_stall = cyc;
    for (int d = 0; d < 4; d++) begin
      chk("in_ready", d, 32'(in_rdy[d]), 32'(OUT_READY || (expq[d].size() < st[d])));
      if (hold[d]) chk_out("hold", d, 1'b1, hs[d], hc[d]);
      if (out_vld[d] && OUT_READY) begin
        chk("emit_has_item", d, 32'(expq[d].size() != 0), 32'd1);
        if (expq[d].size() != 0) begin
          e = expq[d].pop_front();
          chk("sum",  d, 32'(get_sum(d)), 32'(e.s));
          chk("cout", d, 32'(cout_v[d]),  32'(e.c));
          if (last_stall < int'(e.acc)) chk("latency", d, 32'(cyc - int'(e.acc)), 32'(st[d]));
          else chk("latency_min", d, 32'(cyc - int'(e.acc) >= st[d]), 32'd1);
        end
      end
      hold[d] = out_vld[d] && !OUT_READY;
      hs[d]   = get_sum(d);
      hc[d]   = cout_v[d];
      if (IN_VALID && in_rdy[d]) begin
        expq[d].push_back(ref_add(d));
        acc_cnt[d]++;
      end
    end
    @(negedge CLK);
    cyc++;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c);
    A = a; B = b; CIN = c; IN_VALID = 1'b1;
    cycle();
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    for (int d = 0; d < 4; d++) chk("drained", d, 32'(expq[d].size()), 32'd0);
  endtask

  // Asynchronous reset raised between edges; outputs must clear before the next edge.
  task automatic mid_reset();
    IN_VALID = 1'b0;
    #2 RESET = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk_out("async_rst", d, 1'b0, 8'h00, 1'b0);
      chk("async_rst_ready", d, 32'(in_rdy[d]), 32'd1);
      expq[d].delete();
      hold[d] = 1'b0;
    end
    @(negedge CLK);
    cyc++;
    RESET = 1'b0;
  endtask

  initial begin
    int base [4];

    #2;
    for (int d = 0; d < 4; d++) begin
      chk_out("reset", d, 1'b0, 8'h00, 1'b0);
      chk("reset_ready", d, 32'(in_rdy[d]), 32'd1);
    end
    @(negedge CLK);
    RESET = 1'b0;

    // 0xFF + 0x01 wraps to 0x00 with carry, two cycles through the 8/2 pipe.
    send(8'hFF, 8'h01, 1'b0);
    cycle();
    chk_out("wrap", 0, 1'b1, 8'h00, 1'b1);
    drain();

    // Back-to-back stream, then a fully carried pattern across all configurations.
    send(8'h0F, 8'h01, 1'b0);
    send(8'h80, 8'h80, 1'b1);
    send(8'h7F, 8'h00, 1'b1);
    drain();

    send(8'hAA, 8'h55, 1'b1);
    chk_out("aa55_s1", 2, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) cycle();
    chk_out("aa55_s8", 1, 1'b1, 8'h00, 1'b1);
    drain();

    send(8'h1F, 8'h1F, 1'b1);
    cycle();
    chk_out("w5_uneven", 3, 1'b1, 8'h1F, 1'b1);
    drain();

    // Backpressure from an empty pipe: each DUT takes exactly as many as it has stages.
    for (int d = 0; d < 4; d++) base[d] = acc_cnt[d];
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      A = 8'($urandom); B = 8'($urandom); CIN = 1'($urandom); IN_VALID = 1'b1;
      cycle();
    end
    for (int d = 0; d < 4; d++)
      chk("bp_accepts", d, 32'(acc_cnt[d] - base[d]), 32'((st[d] < 5) ? st[d] : 5));
    drain();

    // Reset with results in flight, then a fresh add.
    send(8'h33, 8'h44, 1'b0);
    send(8'h12, 8'h34, 1'b1);
    mid_reset();
    send(8'h01, 8'h01, 1'b0);
    cycle();
    chk_out("post_rst", 0, 1'b1, 8'h02, 1'b0);
    drain();

    // Randomised traffic with random backpressure and one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      A = 8'($urandom);
      B = 8'($urandom);
      CIN = 1'($urandom);
      IN_VALID = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 9) < 7);
      if (i == 300) mid_reset();
      else cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
